// File: rtl/decode_operand_stage_if.sv
// Purpose : bundle of every non-clock/reset signal of the RV32I decode/operand stage.
// Signals : upstream handshake (i_valid/o_ready, i_instr, i_pc),
//           register-file port (o_Rnum1/2, i_Rd1/2) and writeback (i_wb_en/num/data),
//           i_flush redirect, downstream bundle (o_valid/i_ready, o_pc, operands, decode fields).
// Modports: slave  = the stage itself (consumes i_*, produces o_*)
//           master = the environment around it (produces i_*, consumes o_*)
interface decode_operand_stage_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned ILEN = 32;
  localparam int unsigned RW   = 5;

  // Upstream handshake
  logic            i_valid;
  logic            o_ready;
  logic [ILEN-1:0] i_instr;
  logic [XLEN-1:0] i_pc;

  // Register-file read port
  logic [RW-1:0]   o_Rnum1;
  logic [RW-1:0]   o_Rnum2;
  logic [XLEN-1:0] i_Rd1;
  logic [XLEN-1:0] i_Rd2;

  // Writeback snoop
  logic            i_wb_en;
  logic [RW-1:0]   i_wb_num;
  logic [XLEN-1:0] i_wb_data;

  // Redirect
  logic            i_flush;

  // Downstream bundle
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_rs1_val;
  logic [XLEN-1:0] o_rs2_val;
  logic [XLEN-1:0] o_imm;
  logic [RW-1:0]   o_rd;
  logic [RW-1:0]   o_rs1;
  logic [RW-1:0]   o_rs2;
  logic [6:0]      o_opcode;
  logic [2:0]      o_funct3;
  logic            o_funct7b5;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_instr, i_pc, i_Rd1, i_Rd2,
           i_wb_en, i_wb_num, i_wb_data, i_flush, i_ready,
    output o_ready, o_Rnum1, o_Rnum2, o_valid, o_pc, o_rs1_val, o_rs2_val,
           o_imm, o_rd, o_rs1, o_rs2, o_opcode, o_funct3, o_funct7b5, o_illegal
  );

  modport master (
    output i_valid, i_instr, i_pc, i_Rd1, i_Rd2,
           i_wb_en, i_wb_num, i_wb_data, i_flush, i_ready,
    input  o_ready, o_Rnum1, o_Rnum2, o_valid, o_pc, o_rs1_val, o_rs2_val,
           o_imm, o_rd, o_rs1, o_rs2, o_opcode, o_funct3, o_funct7b5, o_illegal
  );
endinterface

// File: rtl/decode_operand_stage.sv
// Purpose : RV32I decode/operand-fetch stage in front of the register file. Accepts one
//           instruction+PC per handshake, drives register-file read addresses, builds the
//           immediate, bypasses same-cycle writebacks into the operands and holds a single
//           registered decode bundle for execute.
// Ports   : i_clk  - clock (posedge)
//           i_rst  - synchronous active-high reset
//           bus    - decode_operand_stage_if.slave (handshakes, register-file port,
//                    writeback snoop, flush, decode bundle)
module decode_operand_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  decode_operand_stage_if.slave  bus
);

  localparam int unsigned ILEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Bundle registers
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [RW-1:0]   r_rd;
  logic [RW-1:0]   r_rs1;
  logic [RW-1:0]   r_rs2;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic            r_illegal;

  // Field extraction of the incoming word
  logic [ILEN-1:0] w_instr;
  logic [6:0]      w_opcode;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [RW-1:0]   w_rd;
  logic [2:0]      w_funct3;
  logic            w_funct7b5;

  assign w_instr    = bus.i_instr;
  assign w_opcode   = w_instr[6:0];
  assign w_rd       = w_instr[11:7];
  assign w_funct3   = w_instr[14:12];
  assign w_rs1      = w_instr[19:15];
  assign w_rs2      = w_instr[24:20];
  assign w_funct7b5 = w_instr[30];

  // Register-file read addresses go straight out so the data returns this cycle
  assign bus.o_Rnum1 = w_rs1;
  assign bus.o_Rnum2 = w_rs2;

  // Single-entry stage: free when empty or when execute drains it this cycle
  logic w_ready;
  logic w_capture;

  assign w_ready     = !r_valid || bus.i_ready;
  assign bus.o_ready = w_ready;
  assign w_capture   = bus.i_valid && w_ready;

  // Immediate generation and legality check
  logic [ILEN-1:0] w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;

  always_comb begin
    w_imm32   = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      OP_STORE:
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      OP_BRANCH:
        w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                   w_instr[30:25], w_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm32 = {w_instr[31:12], 12'b0};
      OP_JAL:
        w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                   w_instr[20], w_instr[30:21], 1'b0};
      OP_OP, OP_FENCE:
        w_imm32 = '0;
      default:
        w_illegal = 1'b1;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // Capture-time operands: the register file returns the pre-write value on a
  // same-cycle read/write collision, so forward the writeback data. x0 reads as 0.
  logic            w_wb_live;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;

  assign w_wb_live = bus.i_wb_en && (bus.i_wb_num != '0);

  always_comb begin
    w_op1 = bus.i_Rd1;
    w_op2 = bus.i_Rd2;
    if (w_rs1 == '0)
      w_op1 = '0;
    else if (w_wb_live && (bus.i_wb_num == w_rs1))
      w_op1 = bus.i_wb_data;
    if (w_rs2 == '0)
      w_op2 = '0;
    else if (w_wb_live && (bus.i_wb_num == w_rs2))
      w_op2 = bus.i_wb_data;
  end

  // Held-bundle refresh: a stalled bundle must still see writebacks to its sources
  logic w_hold_hit1;
  logic w_hold_hit2;

  assign w_hold_hit1 = w_wb_live && (bus.i_wb_num == r_rs1);
  assign w_hold_hit2 = w_wb_live && (bus.i_wb_num == r_rs2);

  // Bundle register update: reset > flush > capture > hand-off > hold
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (bus.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_pc       <= bus.i_pc;
      r_rs1_val  <= w_op1;
      r_rs2_val  <= w_op2;
      r_imm      <= w_imm;
      r_rd       <= w_rd;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_opcode   <= w_opcode;
      r_funct3   <= w_funct3;
      r_funct7b5 <= w_funct7b5;
      r_illegal  <= w_illegal;
    end else if (r_valid && bus.i_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      if (w_hold_hit1) r_rs1_val <= bus.i_wb_data;
      if (w_hold_hit2) r_rs2_val <= bus.i_wb_data;
    end
  end

  // Bundle outputs
  assign bus.o_valid    = r_valid;
  assign bus.o_pc       = r_pc;
  assign bus.o_rs1_val  = r_rs1_val;
  assign bus.o_rs2_val  = r_rs2_val;
  assign bus.o_imm      = r_imm;
  assign bus.o_rd       = r_rd;
  assign bus.o_rs1      = r_rs1;
  assign bus.o_rs2      = r_rs2;
  assign bus.o_opcode   = r_opcode;
  assign bus.o_funct3   = r_funct3;
  assign bus.o_funct7b5 = r_funct7b5;
  assign bus.o_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_operand_stage.sv
module tb_decode_operand_stage;
  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;

  decode_operand_stage_if #(.XLEN(XLEN)) bus ();

  decode_operand_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Register-file contents as seen by the bench (x0 stays 0)
  logic [31:0] rf [32];

  // Expected bundle state for the randomized run
  logic        m_valid;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7, m_ill;

  // Immediate built from field arithmetic rather than bit concatenation
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [6:0]  op;
    logic [31:0] sgn;
    op  = ins[6:0];
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    case (op)
      7'h03, 7'h13, 7'h67, 7'h73: return 32'($signed(ins) >>> 20);
      7'h23: return (32'($signed(ins) >>> 25) << 5) | ((ins >> 7) & 32'h1F);
      7'h63: return (sgn & 32'hFFFF_F000) | (((ins >> 7) & 32'h1) << 11) |
                    (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      7'h6F: return (sgn & 32'hFFF0_0000) | (((ins >> 12) & 32'hFF) << 12) |
                    (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return !(op inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                        7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_valid   = 1'b0;
    bus.i_instr   = 32'h0000_0013;
    bus.i_pc      = 32'h0;
    bus.i_Rd1     = 32'h0;
    bus.i_Rd2     = 32'h0;
    bus.i_wb_en   = 1'b0;
    bus.i_wb_num  = 5'd0;
    bus.i_wb_data = 32'h0;
    bus.i_flush   = 1'b0;
    bus.i_ready   = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.o_valid); end
    checks++; if (bus.o_pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", bus.o_pc, RESET_PC); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.o_ready); end
    checks++; if (bus.o_imm !== 32'h0 || bus.o_rd !== 5'd0 || bus.o_illegal !== 1'b0)
      begin errors++; $display("FAIL reset_fields imm=%h rd=%0d ill=%0b want 0", bus.o_imm, bus.o_rd, bus.o_illegal); end
  endtask

  task automatic test_addi();
    bus.i_valid = 1'b1; bus.i_instr = 32'hFFF0_0293; bus.i_pc = 32'h100;
    bus.i_Rd1 = 32'hDEAD_BEEF; bus.i_ready = 1'b1;
    #1;
    checks++; if (bus.o_Rnum1 !== 5'd0 || bus.o_Rnum2 !== 5'd31)
      begin errors++; $display("FAIL addi_rnum got %0d/%0d want 0/31", bus.o_Rnum1, bus.o_Rnum2); end
    tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", bus.o_valid); end
    checks++; if (bus.o_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", bus.o_imm); end
    checks++; if (bus.o_rd !== 5'd5) begin errors++; $display("FAIL addi_rd got %0d want 5", bus.o_rd); end
    checks++; if (bus.o_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", bus.o_pc); end
    checks++; if (bus.o_rs1_val !== 32'h0) begin errors++; $display("FAIL addi_x0 got %h want 0", bus.o_rs1_val); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %0b want 0", bus.o_valid); end
  endtask

  task automatic test_bypass();
    bus.i_valid = 1'b1; bus.i_instr = 32'h0020_81B3; bus.i_pc = 32'h104;
    bus.i_Rd1 = 32'h7; bus.i_Rd2 = 32'h9;
    bus.i_wb_en = 1'b1; bus.i_wb_num = 5'd1; bus.i_wb_data = 32'h55;
    tick();
    checks++; if (bus.o_rs1_val !== 32'h55) begin errors++; $display("FAIL bypass_rs1 got %h want 55", bus.o_rs1_val); end
    checks++; if (bus.o_rs2_val !== 32'h9) begin errors++; $display("FAIL bypass_rs2_nohit got %h want 9", bus.o_rs2_val); end
    bus.i_instr = 32'h0020_01B3; bus.i_wb_num = 5'd0;
    tick();
    checks++; if (bus.o_rs1_val !== 32'h0) begin errors++; $display("FAIL bypass_x0 got %h want 0", bus.o_rs1_val); end
    idle_inputs();
    tick();
  endtask

  task automatic test_hold();
    bus.i_valid = 1'b1; bus.i_instr = 32'h0020_81B3; bus.i_pc = 32'h200;
    bus.i_Rd1 = 32'h11; bus.i_Rd2 = 32'h22; bus.i_ready = 1'b0;
    tick();
    bus.i_instr = 32'hFFF0_0293; bus.i_pc = 32'h300;
    for (int c = 1; c <= 3; c++) begin
      bus.i_wb_en = (c == 2); bus.i_wb_num = 5'd2; bus.i_wb_data = 32'hABCD;
      #1;
      checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL hold_ready c%0d got %0b want 0", c, bus.o_ready); end
      tick();
      checks++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h200 || bus.o_rd !== 5'd3 || bus.o_rs1_val !== 32'h11)
        begin errors++; $display("FAIL hold_fields c%0d v=%0b pc=%h rd=%0d rs1=%h want 1/200/3/11",
                                 c, bus.o_valid, bus.o_pc, bus.o_rd, bus.o_rs1_val); end
      checks++; if (bus.o_rs2_val !== ((c >= 2) ? 32'hABCD : 32'h22))
        begin errors++; $display("FAIL hold_rs2 c%0d got %h want %h", c, bus.o_rs2_val, (c >= 2) ? 32'hABCD : 32'h22); end
    end
    idle_inputs();
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %0b want 0", bus.o_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      bus.i_valid = 1'b1; bus.i_ready = 1'b1;
      bus.i_instr = 32'h0000_0013 | (32'(k + 1) << 7) | (32'(k) << 20);
      bus.i_pc = 32'h1000 + 32'(4 * k);
      tick();
      checks++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h1000 + 32'(4 * k) || bus.o_rd !== 5'(k + 1) || bus.o_imm !== 32'(k))
        begin errors++; $display("FAIL stream_%0d v=%0b pc=%h rd=%0d imm=%h", k, bus.o_valid, bus.o_pc, bus.o_rd, bus.o_imm); end
    end
    bus.i_flush = 1'b1; bus.i_pc = 32'h2000;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %0b want 0", bus.o_valid); end
    bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    tick();
    bus.i_valid = 1'b0; bus.i_flush = 1'b1;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL flush_held got %0b want 0", bus.o_valid); end
    idle_inputs();
  endtask

  task automatic test_branch_illegal();
    bus.i_valid = 1'b1; bus.i_instr = 32'hFE00_0EE3; bus.i_pc = 32'h400;
    tick();
    checks++; if (bus.o_imm !== 32'hFFFF_FFFC || bus.o_illegal !== 1'b0)
      begin errors++; $display("FAIL beq_imm got %h ill=%0b want fffffffc/0", bus.o_imm, bus.o_illegal); end
    bus.i_instr = 32'h0000_007F;
    tick();
    checks++; if (bus.o_illegal !== 1'b1 || bus.o_valid !== 1'b1 || bus.o_opcode !== 7'h7F)
      begin errors++; $display("FAIL illegal got ill=%0b v=%0b op=%h want 1/1/7f", bus.o_illegal, bus.o_valid, bus.o_opcode); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_hold();
    bus.i_valid = 1'b1; bus.i_instr = 32'hFFF0_0293; bus.i_pc = 32'h500; bus.i_ready = 1'b0;
    tick();
    bus.i_valid = 1'b0;
    tick();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL rsthold_pre got %0b want 1", bus.o_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_pc !== RESET_PC || bus.o_ready !== 1'b1)
      begin errors++; $display("FAIL rsthold v=%0b pc=%h rdy=%0b want 0/%h/1", bus.o_valid, bus.o_pc, bus.o_ready, RESET_PC); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [6:0]  ops [12];
    logic [31:0] ins;
    logic        rdy, cap, exp_rdy;
    logic [31:0] e1, e2;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h5B};
    do_reset();
    m_valid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      rst           = ($urandom_range(0, 49) == 0);
      bus.i_valid   = ($urandom_range(0, 9) < 7);
      bus.i_ready   = ($urandom_range(0, 9) < 6);
      bus.i_flush   = ($urandom_range(0, 9) == 0);
      bus.i_instr   = ins;
      bus.i_pc      = $urandom;
      bus.i_Rd1     = (ins[19:15] == 5'd0) ? $urandom : rf[ins[19:15]];
      bus.i_Rd2     = (ins[24:20] == 5'd0) ? $urandom : rf[ins[24:20]];
      bus.i_wb_en   = $urandom_range(0, 1);
      bus.i_wb_num  = 5'($urandom_range(0, 3));
      bus.i_wb_data = $urandom;
      rdy     = bus.i_ready;
      exp_rdy = !m_valid || rdy;
      #1;
      checks++; if (bus.o_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready n%0d got %0b want %0b", n, bus.o_ready, exp_rdy); end
      checks++; if (bus.o_Rnum1 !== ins[19:15] || bus.o_Rnum2 !== ins[24:20])
        begin errors++; $display("FAIL rnd_rnum n%0d got %0d/%0d want %0d/%0d", n, bus.o_Rnum1, bus.o_Rnum2, ins[19:15], ins[24:20]); end
      cap = bus.i_valid && exp_rdy && !bus.i_flush && !rst;
      if (rst || bus.i_flush) m_valid = 1'b0;
      else if (cap) begin
        m_valid = 1'b1;
        m_pc  = bus.i_pc;  m_imm = ref_imm(ins); m_ill = ref_illegal(ins);
        m_rd  = ins[11:7]; m_rs1 = ins[19:15];   m_rs2 = ins[24:20];
        m_op  = ins[6:0];  m_f3  = ins[14:12];   m_f7  = ins[30];
      end else if (m_valid && rdy) m_valid = 1'b0;
      // The register file commits the writeback at this edge; a live bundle always
      // carries the architecturally current values of its sources.
      if (bus.i_wb_en && bus.i_wb_num != 5'd0) rf[bus.i_wb_num] = bus.i_wb_data;
      tick();
      rst = 1'b0;
      checks++; if (bus.o_valid !== m_valid) begin errors++; $display("FAIL rnd_valid n%0d got %0b want %0b", n, bus.o_valid, m_valid); end
      if (m_valid) begin
        e1 = (m_rs1 == 5'd0) ? 32'h0 : rf[m_rs1];
        e2 = (m_rs2 == 5'd0) ? 32'h0 : rf[m_rs2];
        checks++; if (bus.o_pc !== m_pc || bus.o_imm !== m_imm || bus.o_illegal !== m_ill)
          begin errors++; $display("FAIL rnd_dec n%0d pc=%h imm=%h ill=%0b want %h/%h/%0b", n, bus.o_pc, bus.o_imm, bus.o_illegal, m_pc, m_imm, m_ill); end
        checks++; if (bus.o_rd !== m_rd || bus.o_rs1 !== m_rs1 || bus.o_rs2 !== m_rs2 ||
                      bus.o_opcode !== m_op || bus.o_funct3 !== m_f3 || bus.o_funct7b5 !== m_f7)
          begin errors++; $display("FAIL rnd_fields n%0d rd=%0d rs=%0d/%0d op=%h f3=%0d f7=%0b", n, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_opcode, bus.o_funct3, bus.o_funct7b5); end
        checks++; if (bus.o_rs1_val !== e1 || bus.o_rs2_val !== e2)
          begin errors++; $display("FAIL rnd_ops n%0d got %h/%h want %h/%h", n, bus.o_rs1_val, bus.o_rs2_val, e1, e2); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_addi();
    test_bypass();
    test_hold();
    test_back_to_back();
    test_branch_illegal();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
